// File: rtl/mc_control.sv
// Multi-cycle MIPS-style control unit: Moore FSM that sequences fetch, decode,
// execute, memory and write-back for a small integer subset.
// Optional build macro: MC_CONTROL_MEMWAIT_EN -- memory states stall on i_mem_ready.
// Outputs are decoded from the current state and the opcode/funct latched at the
// end of DECODE, and are forced inactive while rst_n is low.
module mc_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    input  logic       i_zero,
    input  logic       i_mem_ready,
    output logic       o_pc_we,
    output logic       o_ir_we,
    output logic       o_mem_re,
    output logic       o_mem_we,
    output logic       o_reg_we,
    output logic       o_iord,
    output logic [1:0] o_reg_dst,
    output logic [1:0] o_mem_to_reg,
    output logic       o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [3:0] o_alu_ctrl,
    output logic       o_ext_zero,
    output logic [1:0] o_pc_src,
    output logic       o_illegal
);

    localparam int unsigned OPW  = 6;
    localparam int unsigned ALUW = 4;

    localparam logic [OPW-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPW-1:0] OP_J     = 6'h02;
    localparam logic [OPW-1:0] OP_JAL   = 6'h03;
    localparam logic [OPW-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPW-1:0] OP_BNE   = 6'h05;
    localparam logic [OPW-1:0] OP_ADDI  = 6'h08;
    localparam logic [OPW-1:0] OP_ADDIU = 6'h09;
    localparam logic [OPW-1:0] OP_SLTI  = 6'h0A;
    localparam logic [OPW-1:0] OP_SLTIU = 6'h0B;
    localparam logic [OPW-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OPW-1:0] OP_ORI   = 6'h0D;
    localparam logic [OPW-1:0] OP_LW    = 6'h23;
    localparam logic [OPW-1:0] OP_SW    = 6'h2B;
    localparam logic [OPW-1:0] FN_JR    = 6'h08;

    localparam logic [ALUW-1:0] ALU_NOP  = 4'b0000;
    localparam logic [ALUW-1:0] ALU_ADD  = 4'b0001;
    localparam logic [ALUW-1:0] ALU_SUB  = 4'b0010;
    localparam logic [ALUW-1:0] ALU_AND  = 4'b0011;
    localparam logic [ALUW-1:0] ALU_OR   = 4'b0100;
    localparam logic [ALUW-1:0] ALU_NOR  = 4'b0101;
    localparam logic [ALUW-1:0] ALU_SLT  = 4'b0110;
    localparam logic [ALUW-1:0] ALU_SLL  = 4'b0111;
    localparam logic [ALUW-1:0] ALU_SRL  = 4'b1000;
    localparam logic [ALUW-1:0] ALU_SRA  = 4'b1001;
    localparam logic [ALUW-1:0] ALU_SLTU = 4'b1010;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
        S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BRANCH, S_JUMP, S_JR, S_HALT
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [OPW-1:0]    r_opcode;
    logic [OPW-1:0]    r_funct;
    logic              r_illegal;
    logic [ALUW-1:0]   w_r_alu;
    logic              w_r_ok;
    logic              w_mem_done;

`ifdef MC_CONTROL_MEMWAIT_EN
    assign w_mem_done = i_mem_ready;
`else
    // Zero-wait memory: every access completes in its first cycle.
    logic w_unused_mem_ready;
    assign w_unused_mem_ready = i_mem_ready;
    assign w_mem_done         = 1'b1;
`endif

    assign o_illegal = r_illegal;

    // State, latched instruction fields and sticky illegal flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_opcode  <= '0;
            r_funct   <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_DECODE) begin
                r_opcode <= i_opcode;
                r_funct  <= i_funct;
            end
            if (w_state_next == S_HALT) begin
                r_illegal <= 1'b1;
            end
        end
    end

    // R-type funct to ALU operation; w_r_ok low flags an undecoded funct.
    always_comb begin
        w_r_alu = ALU_NOP;
        w_r_ok  = 1'b1;
        case (r_funct)
            6'h20, 6'h21: w_r_alu = ALU_ADD;
            6'h22, 6'h23: w_r_alu = ALU_SUB;
            6'h24:        w_r_alu = ALU_AND;
            6'h25:        w_r_alu = ALU_OR;
            6'h27:        w_r_alu = ALU_NOR;
            6'h2A:        w_r_alu = ALU_SLT;
            6'h2B:        w_r_alu = ALU_SLTU;
            6'h00:        w_r_alu = ALU_SLL;
            6'h02:        w_r_alu = ALU_SRL;
            6'h03:        w_r_alu = ALU_SRA;
            default:      w_r_ok  = 1'b0;
        endcase
    end

    // Next-state and Moore output decode; everything idles while in reset.
    always_comb begin
        w_state_next = r_state;
        o_pc_we      = 1'b0;
        o_ir_we      = 1'b0;
        o_mem_re     = 1'b0;
        o_mem_we     = 1'b0;
        o_reg_we     = 1'b0;
        o_iord       = 1'b0;
        o_reg_dst    = 2'd0;
        o_mem_to_reg = 2'd0;
        o_alu_src_a  = 1'b0;
        o_alu_src_b  = 2'd0;
        o_alu_ctrl   = ALU_NOP;
        o_ext_zero   = 1'b0;
        o_pc_src     = 2'd0;

        case (r_state)
            S_FETCH: begin
                o_mem_re    = 1'b1;
                o_ir_we     = w_mem_done;
                o_pc_we     = w_mem_done;
                o_alu_src_b = 2'd1;
                o_alu_ctrl  = ALU_ADD;
                if (w_mem_done) begin
                    w_state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                o_alu_src_b = 2'd3;
                o_alu_ctrl  = ALU_ADD;
                case (i_opcode)
                    OP_LW, OP_SW:   w_state_next = S_MEM_ADDR;
                    OP_RTYPE:       w_state_next = (i_funct == FN_JR) ? S_JR : S_EXEC_R;
                    OP_BEQ, OP_BNE: w_state_next = S_BRANCH;
                    OP_J, OP_JAL:   w_state_next = S_JUMP;
                    OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI:
                                    w_state_next = S_EXEC_I;
                    default:        w_state_next = S_HALT;
                endcase
            end
            S_EXEC_R: begin
                o_alu_src_a = 1'b1;
                if (w_r_ok) begin
                    o_alu_ctrl   = w_r_alu;
                    w_state_next = S_ALU_WB;
                end else begin
                    w_state_next = S_HALT;
                end
            end
            S_EXEC_I: begin
                o_alu_src_a  = 1'b1;
                o_alu_src_b  = 2'd2;
                w_state_next = S_ALU_WB;
                case (r_opcode)
                    OP_ADDI, OP_ADDIU: o_alu_ctrl = ALU_ADD;
                    OP_SLTI:           o_alu_ctrl = ALU_SLT;
                    OP_SLTIU:          o_alu_ctrl = ALU_SLTU;
                    OP_ANDI: begin
                        o_alu_ctrl = ALU_AND;
                        o_ext_zero = 1'b1;
                    end
                    OP_ORI: begin
                        o_alu_ctrl = ALU_OR;
                        o_ext_zero = 1'b1;
                    end
                    default:           o_alu_ctrl = ALU_NOP;
                endcase
            end
            S_ALU_WB: begin
                o_reg_we     = 1'b1;
                o_reg_dst    = (r_opcode == OP_RTYPE) ? 2'd1 : 2'd0;
                w_state_next = S_FETCH;
            end
            S_MEM_ADDR: begin
                o_alu_src_a  = 1'b1;
                o_alu_src_b  = 2'd2;
                o_alu_ctrl   = ALU_ADD;
                w_state_next = (r_opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                o_mem_re = 1'b1;
                o_iord   = 1'b1;
                if (w_mem_done) begin
                    w_state_next = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                o_reg_we     = 1'b1;
                o_mem_to_reg = 2'd1;
                w_state_next = S_FETCH;
            end
            S_MEM_WR: begin
                o_mem_we = 1'b1;
                o_iord   = 1'b1;
                if (w_mem_done) begin
                    w_state_next = S_FETCH;
                end
            end
            S_BRANCH: begin
                o_alu_src_a  = 1'b1;
                o_alu_ctrl   = ALU_SUB;
                o_pc_src     = 2'd1;
                o_pc_we      = (r_opcode == OP_BEQ) ? i_zero : ~i_zero;
                w_state_next = S_FETCH;
            end
            S_JUMP: begin
                o_pc_src = 2'd2;
                o_pc_we  = 1'b1;
                if (r_opcode == OP_JAL) begin
                    o_reg_we     = 1'b1;
                    o_reg_dst    = 2'd2;
                    o_mem_to_reg = 2'd2;
                end
                w_state_next = S_FETCH;
            end
            S_JR: begin
                o_pc_src     = 2'd3;
                o_pc_we      = 1'b1;
                w_state_next = S_FETCH;
            end
            S_HALT: begin
                w_state_next = S_HALT;
            end
            default: begin
                w_state_next = S_FETCH;
            end
        endcase

        if (!rst_n) begin
            o_pc_we      = 1'b0;
            o_ir_we      = 1'b0;
            o_mem_re     = 1'b0;
            o_mem_we     = 1'b0;
            o_reg_we     = 1'b0;
            o_iord       = 1'b0;
            o_reg_dst    = 2'd0;
            o_mem_to_reg = 2'd0;
            o_alu_src_a  = 1'b0;
            o_alu_src_b  = 2'd0;
            o_alu_ctrl   = ALU_NOP;
            o_ext_zero   = 1'b0;
            o_pc_src     = 2'd0;
        end
    end

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: each instruction pushes its expected
// per-cycle control vector; vectors are popped and compared on the falling edge.
module tb_mc_control;

    logic       clk;
    logic       rst_n;
    logic [5:0] i_opcode;
    logic [5:0] i_funct;
    logic       i_zero;
    logic       i_mem_ready;
    logic       o_pc_we, o_ir_we, o_mem_re, o_mem_we, o_reg_we, o_iord;
    logic [1:0] o_reg_dst, o_mem_to_reg;
    logic       o_alu_src_a;
    logic [1:0] o_alu_src_b;
    logic [3:0] o_alu_ctrl;
    logic       o_ext_zero;
    logic [1:0] o_pc_src;
    logic       o_illegal;

    int n_checks;
    int n_fail;

    logic [20:0] exp_q[$];
    logic [20:0] w_obs;

    mc_control dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_opcode     (i_opcode),
        .i_funct      (i_funct),
        .i_zero       (i_zero),
        .i_mem_ready  (i_mem_ready),
        .o_pc_we      (o_pc_we),
        .o_ir_we      (o_ir_we),
        .o_mem_re     (o_mem_re),
        .o_mem_we     (o_mem_we),
        .o_reg_we     (o_reg_we),
        .o_iord       (o_iord),
        .o_reg_dst    (o_reg_dst),
        .o_mem_to_reg (o_mem_to_reg),
        .o_alu_src_a  (o_alu_src_a),
        .o_alu_src_b  (o_alu_src_b),
        .o_alu_ctrl   (o_alu_ctrl),
        .o_ext_zero   (o_ext_zero),
        .o_pc_src     (o_pc_src),
        .o_illegal    (o_illegal)
    );

    assign w_obs = {o_pc_we, o_ir_we, o_mem_re, o_mem_we, o_reg_we, o_iord,
                    o_reg_dst, o_mem_to_reg, o_alu_src_a, o_alu_src_b,
                    o_alu_ctrl, o_ext_zero, o_pc_src, o_illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected control vector in the same field order as w_obs.
    function automatic logic [20:0] ov(
        input logic pcwe, input logic irwe, input logic re, input logic we,
        input logic rwe, input logic iord, input logic [1:0] rdst,
        input logic [1:0] m2r, input logic a, input logic [1:0] b,
        input logic [3:0] alu, input logic ext, input logic [1:0] psrc,
        input logic ill);
        return {pcwe, irwe, re, we, rwe, iord, rdst, m2r, a, b, alu, ext, psrc, ill};
    endfunction

    task automatic chk(input string tag, input logic [20:0] got, input logic [20:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Compare one queued vector per cycle until the queue is empty.
    task automatic drain(input string tag);
        while (exp_q.size() > 0) begin
            chk(tag, w_obs, exp_q.pop_front());
            @(negedge clk);
        end
    endtask

    logic [20:0] v_fetch, v_decode, v_halt, v_zero;

    // Drive one instruction and queue the control vectors it must produce.
    task automatic run(input string tag, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic [3:0] alu, input logic ext);
        i_opcode = op;
        i_funct  = fn;
        i_zero   = z;
        exp_q.push_back(v_fetch);
        exp_q.push_back(v_decode);
        case (op)
            6'h00: begin
                if (fn == 6'h08) begin
                    exp_q.push_back(ov(1,0,0,0,0,0,2'd0,2'd0,0,2'd0,4'd0,0,2'd3,0));
                end else if (alu != 4'd0) begin
                    exp_q.push_back(ov(0,0,0,0,0,0,2'd0,2'd0,1,2'd0,alu,0,2'd0,0));
                    exp_q.push_back(ov(0,0,0,0,1,0,2'd1,2'd0,0,2'd0,4'd0,0,2'd0,0));
                end else begin
                    exp_q.push_back(ov(0,0,0,0,0,0,2'd0,2'd0,1,2'd0,4'd0,0,2'd0,0));
                    for (int i = 0; i < 10; i++) exp_q.push_back(v_halt);
                end
            end
            6'h23: begin
                exp_q.push_back(ov(0,0,0,0,0,0,2'd0,2'd0,1,2'd2,4'd1,0,2'd0,0));
                exp_q.push_back(ov(0,0,1,0,0,1,2'd0,2'd0,0,2'd0,4'd0,0,2'd0,0));
                exp_q.push_back(ov(0,0,0,0,1,0,2'd0,2'd1,0,2'd0,4'd0,0,2'd0,0));
            end
            6'h2B: begin
                exp_q.push_back(ov(0,0,0,0,0,0,2'd0,2'd0,1,2'd2,4'd1,0,2'd0,0));
                exp_q.push_back(ov(0,0,0,1,0,1,2'd0,2'd0,0,2'd0,4'd0,0,2'd0,0));
            end
            6'h04: exp_q.push_back(ov(z,0,0,0,0,0,2'd0,2'd0,1,2'd0,4'd2,0,2'd1,0));
            6'h05: exp_q.push_back(ov(~z,0,0,0,0,0,2'd0,2'd0,1,2'd0,4'd2,0,2'd1,0));
            6'h02: exp_q.push_back(ov(1,0,0,0,0,0,2'd0,2'd0,0,2'd0,4'd0,0,2'd2,0));
            6'h03: exp_q.push_back(ov(1,0,0,0,1,0,2'd2,2'd2,0,2'd0,4'd0,0,2'd2,0));
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D: begin
                exp_q.push_back(ov(0,0,0,0,0,0,2'd0,2'd0,1,2'd2,alu,ext,2'd0,0));
                exp_q.push_back(ov(0,0,0,0,1,0,2'd0,2'd0,0,2'd0,4'd0,0,2'd0,0));
            end
            default: for (int i = 0; i < 12; i++) exp_q.push_back(v_halt);
        endcase
        drain(tag);
    endtask

    // Reset pulse spanning a rising edge; outputs must idle and illegal clear at once.
    task automatic pulse_reset(input string tag);
        rst_n = 1'b0;
        #1;
        chk(tag, w_obs, v_zero);
        @(negedge clk);
        chk({tag, "_hold"}, w_obs, v_zero);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        v_fetch     = ov(1,1,1,0,0,0,2'd0,2'd0,0,2'd1,4'd1,0,2'd0,0);
        v_decode    = ov(0,0,0,0,0,0,2'd0,2'd0,0,2'd3,4'd1,0,2'd0,0);
        v_halt      = ov(0,0,0,0,0,0,2'd0,2'd0,0,2'd0,4'd0,0,2'd0,1);
        v_zero      = '0;
        rst_n       = 1'b0;
        i_opcode    = 6'h00;
        i_funct     = 6'h20;
        i_zero      = 1'b0;
        i_mem_ready = 1'b1;

        @(negedge clk);
        chk("reset_idle", w_obs, v_zero);
        @(negedge clk);
        chk("reset_idle2", w_obs, v_zero);
        rst_n = 1'b1;
        #1;

        run("add",   6'h00, 6'h20, 1'b0, 4'b0001, 1'b0);
        run("subu",  6'h00, 6'h23, 1'b0, 4'b0010, 1'b0);
        run("nor",   6'h00, 6'h27, 1'b0, 4'b0101, 1'b0);
        run("sltu",  6'h00, 6'h2B, 1'b0, 4'b1010, 1'b0);
        run("sll",   6'h00, 6'h00, 1'b0, 4'b0111, 1'b0);
        run("sra",   6'h00, 6'h03, 1'b0, 4'b1001, 1'b0);
        run("ori",   6'h0D, 6'h15, 1'b0, 4'b0100, 1'b1);
        run("sltiu", 6'h0B, 6'h00, 1'b0, 4'b1010, 1'b0);
        run("andi",  6'h0C, 6'h2A, 1'b0, 4'b0011, 1'b1);
        run("addi",  6'h08, 6'h00, 1'b0, 4'b0001, 1'b0);
        run("slti",  6'h0A, 6'h00, 1'b0, 4'b0110, 1'b0);
        run("lw",    6'h23, 6'h00, 1'b0, 4'b0000, 1'b0);
        run("sw",    6'h2B, 6'h00, 1'b0, 4'b0000, 1'b0);
        run("beq_z0", 6'h04, 6'h00, 1'b0, 4'b0000, 1'b0);
        run("beq_z1", 6'h04, 6'h00, 1'b1, 4'b0000, 1'b0);
        run("bne_z0", 6'h05, 6'h00, 1'b0, 4'b0000, 1'b0);
        run("bne_z1", 6'h05, 6'h00, 1'b1, 4'b0000, 1'b0);
        run("j",     6'h02, 6'h00, 1'b0, 4'b0000, 1'b0);
        run("jal",   6'h03, 6'h00, 1'b0, 4'b0000, 1'b0);
        run("jr",    6'h00, 6'h08, 1'b0, 4'b0000, 1'b0);

`ifdef MC_CONTROL_MEMWAIT_EN
        // lw with three not-ready cycles in MEM_RD.
        i_opcode = 6'h23;
        i_funct  = 6'h00;
        exp_q.push_back(v_fetch);
        exp_q.push_back(v_decode);
        exp_q.push_back(ov(0,0,0,0,0,0,2'd0,2'd0,1,2'd2,4'd1,0,2'd0,0));
        drain("lw_wait_addr");
        i_mem_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            exp_q.push_back(ov(0,0,1,0,0,1,2'd0,2'd0,0,2'd0,4'd0,0,2'd0,0));
        drain("lw_wait_stall");
        i_mem_ready = 1'b1;
        exp_q.push_back(ov(0,0,1,0,0,1,2'd0,2'd0,0,2'd0,4'd0,0,2'd0,0));
        exp_q.push_back(ov(0,0,0,0,1,0,2'd0,2'd1,0,2'd0,4'd0,0,2'd0,0));
        drain("lw_wait_done");
        // Fetch stalls too, with pc_we/ir_we held off until ready.
        i_mem_ready = 1'b0;
        exp_q.push_back(ov(0,0,1,0,0,0,2'd0,2'd0,0,2'd1,4'd1,0,2'd0,0));
        exp_q.push_back(ov(0,0,1,0,0,0,2'd0,2'd0,0,2'd1,4'd1,0,2'd0,0));
        drain("fetch_wait");
        i_mem_ready = 1'b1;
        run("add_after_wait", 6'h00, 6'h21, 1'b0, 4'b0001, 1'b0);
`else
        // mem_ready is ignored: lw with it held low keeps zero-wait timing.
        i_mem_ready = 1'b0;
        run("lw_noready", 6'h23, 6'h00, 1'b0, 4'b0000, 1'b0);
        run("sw_noready", 6'h2B, 6'h00, 1'b0, 4'b0000, 1'b0);
        i_mem_ready = 1'b1;
`endif

        // Illegal opcode: terminal HALT with illegal set.
        run("halt_op", 6'h3F, 6'h00, 1'b0, 4'b0000, 1'b0);
        pulse_reset("halt_reset");
        run("add_after_halt", 6'h00, 6'h20, 1'b0, 4'b0001, 1'b0);

        // Illegal funct: EXEC_R then HALT.
        run("halt_funct", 6'h00, 6'h3F, 1'b0, 4'b0000, 1'b0);
        pulse_reset("funct_reset");

        // Reset in MEM_RD aborts lw before its register write.
        i_opcode = 6'h23;
        i_funct  = 6'h00;
        exp_q.push_back(v_fetch);
        exp_q.push_back(v_decode);
        exp_q.push_back(ov(0,0,0,0,0,0,2'd0,2'd0,1,2'd2,4'd1,0,2'd0,0));
        exp_q.push_back(ov(0,0,1,0,0,1,2'd0,2'd0,0,2'd0,4'd0,0,2'd0,0));
        while (exp_q.size() > 1) begin
            chk("lw_abort_pre", w_obs, exp_q.pop_front());
            @(negedge clk);
        end
        chk("lw_abort_memrd", w_obs, exp_q.pop_front());
        pulse_reset("lw_abort");
        run("sub_after_abort", 6'h00, 6'h22, 1'b0, 4'b0010, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameters: none; the only configuration is the macro in REQ-030.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 opcode  in  6  instruction[31:26] from IR; funct  in  6  instruction[5:0].
REQ-005 zero  in  1  ALU zero flag; mem_ready  in  1  memory access complete.
REQ-006 pc_we, ir_we, mem_re, mem_we, reg_we  out  1 each  write/read strobes.
REQ-007 iord  out  1  memory address select: 0=PC, 1=ALUOut.
REQ-008 reg_dst  out  2  write register: 0=rt, 1=rd, 2=r31.
REQ-009 mem_to_reg  out  2  write data: 0=ALUOut, 1=MDR, 2=PC.
REQ-010 alu_src_a  out  1  0=PC, 1=A; alu_src_b  out  2  0=B, 1=4, 2=sign/zero-ext imm, 3=ext imm<<2.
REQ-011 alu_ctrl  out  4  ALU op: 0000 nop, 0001 add, 0010 sub, 0011 and, 0100 or, 0101 nor, 0110 slt, 1010 sltu, 0111 sll, 1000 srl, 1001 sra.
REQ-012 ext_zero  out  1  1=zero-extend immediate; pc_src  out  2  0=ALU result, 1=ALUOut, 2=jump target, 3=A (jr).
REQ-013 illegal  out  1  sticky flag, set on an undecoded opcode or funct.

Function
REQ-014 The FSM SHALL have states FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, EXEC_I, ALU_WB, BRANCH, JUMP, JR, HALT; outputs are Moore-decoded from state plus the registered opcode/funct.
REQ-015 FETCH: mem_re=1, iord=0, ir_we=1, alu_src_a=0, alu_src_b=1, alu_ctrl=0001, pc_src=0, pc_we=1; advance to DECODE when the access completes (REQ-030).
REQ-016 DECODE: alu_src_a=0, alu_src_b=3, alu_ctrl=0001 (branch target into ALUOut); next state by opcode: 0x23/0x2B->MEM_ADDR, 0x00 with funct 0x08->JR, other 0x00->EXEC_R, 0x04/0x05->BRANCH, 0x02/0x03->JUMP, 0x08/0x09/0x0A/0x0B/0x0C/0x0D->EXEC_I, otherwise->HALT with illegal=1.
REQ-017 EXEC_R: alu_src_a=1, alu_src_b=0; funct map 0x20/0x21->0001, 0x22/0x23->0010, 0x24->0011, 0x25->0100, 0x27->0101, 0x2A->0110, 0x2B->1010, 0x00->0111, 0x02->1000, 0x03->1001; then ALU_WB with reg_dst=1. Any other funct->HALT with illegal=1.
REQ-018 EXEC_I: alu_src_a=1, alu_src_b=2; 0x08/0x09->0001, 0x0A->0110, 0x0B->1010, 0x0C->0011 with ext_zero=1, 0x0D->0100 with ext_zero=1; then ALU_WB with reg_dst=0.
REQ-019 ALU_WB: reg_we=1, mem_to_reg=0; next FETCH.
REQ-020 MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_ctrl=0001; next MEM_RD (lw) or MEM_WR (sw).
REQ-021 MEM_RD: mem_re=1, iord=1, then MEM_WB (reg_we=1, reg_dst=0, mem_to_reg=1), then FETCH; MEM_WR: mem_we=1, iord=1, then FETCH.
REQ-022 BRANCH: alu_src_a=1, alu_src_b=0, alu_ctrl=0010, pc_src=1; pc_we = zero for beq (0x04), ~zero for bne (0x05); next FETCH.
REQ-023 JUMP: pc_src=2, pc_we=1; for jal (0x03) also reg_we=1, reg_dst=2, mem_to_reg=2; next FETCH. JR: pc_src=3, pc_we=1; next FETCH.
REQ-024 HALT is terminal: all strobes 0, alu_ctrl=0000, illegal held 1 until reset.
REQ-025 Strobes not named for a state SHALL be 0 and multi-bit selects 0; at most one of mem_re/mem_we is 1 in any cycle.
REQ-026 Latency (zero wait): R/I-type 4 cycles, lw 5, sw 4, branch/jump/jr 3.

Reset
REQ-027 rst_n low SHALL immediately (asynchronously) force state FETCH and illegal=0, independent of clk.
REQ-028 While rst_n is low, all strobes SHALL be 0, alu_ctrl=0000, selects 0; a reset mid-instruction aborts it with no write.
REQ-029 After rst_n deasserts, the first rising edge evaluates FETCH normally.

Configuration
REQ-030 MC_CONTROL_MEMWAIT_EN defined: FETCH, MEM_RD, MEM_WR hold state with strobes asserted until mem_ready=1, and pc_we/ir_we pulse only in the mem_ready cycle; undefined: mem_ready ignored, every memory state lasts exactly one cycle.

Verification
REQ-031 Reset then add (opcode 0x00, funct 0x20) -> states FETCH,DECODE,EXEC_R,ALU_WB; alu_ctrl=0001 in EXEC_R; reg_we=1, reg_dst=1 exactly once.
REQ-032 ori (0x0D) -> EXEC_I with alu_ctrl=0100, ext_zero=1, reg_dst=0; sltiu (0x0B) -> alu_ctrl=1010, ext_zero=0.
REQ-033 beq with zero=0 -> pc_we=0 in BRANCH; bne with zero=0 -> pc_we=1, pc_src=1.
REQ-034 With MC_CONTROL_MEMWAIT_EN, lw with mem_ready low 3 cycles in MEM_RD -> mem_re held 4 cycles, MEM_WB reached once, reg_we=1, mem_to_reg=1.
REQ-035 opcode 0x3F -> HALT, illegal=1 and all strobes 0 for 10+ cycles; rst_n low mid-lw -> immediate FETCH, illegal=0, no reg_we.
